// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM states, bus width and sign helpers for the HI/LO multiply/divide unit.
// Optional iterative multiply is selected by MUL_ITER_EN in the unit and its datapath core.
package mul_div_unit_pkg;

    localparam int HILO_BUS_WD = 66;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Applies operand signs to an unsigned result: {HI, LO} = {rem, quot} or the 64-bit product.
    function automatic logic [63:0] sign_fix(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] raw);
        logic        neg_q;
        logic        neg_r;
        logic [63:0] res;
        neg_q = ~op[0] & (a[31] ^ b[31]);
        neg_r = ~op[0] & a[31];
        res   = raw;
        if (!op[1]) begin
            res = neg_q ? (~raw + 64'd1) : raw;
        end else begin
            res[31:0]  = neg_q ? (~raw[31:0] + 32'd1) : raw[31:0];
            res[63:32] = neg_r ? (~raw[63:32] + 32'd1) : raw[63:32];
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> mul/div unit bundle: request side plus stall, result pulse and HI/LO write bus.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                   start;
    logic [1:0]             op;
    logic [31:0]            src1;
    logic [31:0]            src2;
    logic                   cancel;
    logic                   stallreq;
    logic                   done;
    logic [31:0]            hi_o;
    logic [31:0]            lo_o;
    logic [HILO_BUS_WD-1:0] hilo_bus;

    modport master (
        output start, op, src1, src2, cancel,
        input  stallreq, done, hi_o, lo_o, hilo_bus
    );

    modport slave (
        input  start, op, src1, src2, cancel,
        output stallreq, done, hi_o, lo_o, hilo_bus
    );

endinterface

// File: rtl/mul_div_unit_div_core.sv
// Restoring radix-2 divider: 32 steps after the load edge; o_done flags the last step's cycle.
// With MUL_ITER_EN the same shift register and 33-bit adder also run a shift-add multiply.
module div_core (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_cancel,
`ifdef MUL_ITER_EN
    input  logic        i_mul,
`endif
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    output logic        o_done,
    output logic [63:0] o_res
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [63:0] r_rq;
    logic [31:0] r_opb;
    logic        w_mul;
    logic        w_cin;
    logic [32:0] w_add_a;
    logic [32:0] w_add_b;
    logic [32:0] w_sum;
    logic [63:0] w_rq_nxt;

`ifdef MUL_ITER_EN
    logic r_mul;
    assign w_mul = r_mul;
`else
    assign w_mul = 1'b0;
`endif

    // Divide: {rem, quot} shifts left and the adder subtracts; multiply: {acc, mplier} shifts right.
    always_comb begin
        w_add_a = r_rq[63:31];
        w_add_b = ~{1'b0, r_opb};
        w_cin   = 1'b1;
        if (w_mul) begin
            w_add_a = {1'b0, r_rq[63:32]};
            w_add_b = r_rq[0] ? {1'b0, r_opb} : 33'd0;
            w_cin   = 1'b0;
        end
        w_sum = w_add_a + w_add_b + {32'd0, w_cin};
        if (w_mul)
            w_rq_nxt = {w_sum, r_rq[31:1]};
        else if (!w_sum[32])
            w_rq_nxt = {w_sum[31:0], r_rq[30:0], 1'b1};
        else
            w_rq_nxt = {r_rq[62:0], 1'b0};
    end

    assign o_done = r_busy & (r_cnt == 5'd31);
    assign o_res  = w_rq_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= 5'd0;
            r_rq   <= 64'd0;
            r_opb  <= 32'd0;
`ifdef MUL_ITER_EN
            r_mul  <= 1'b0;
`endif
        end else if (i_cancel) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= 5'd0;
            r_rq   <= {32'd0, i_opa};
            r_opb  <= i_opb;
`ifdef MUL_ITER_EN
            r_mul  <= i_mul;
`endif
        end else if (r_busy) begin
            r_rq  <= w_rq_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MULT/MULTU/DIV/DIVU unit: DIV done in cycle 33, MUL in cycle 2 (cycle 33 with MUL_ITER_EN).
// Stalls EX from acceptance until DONE; cancel or rst abort silently, rst also clears HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    mul_div_unit_if.slave      md
);

    md_state_e   r_state;
    logic [1:0]  r_op;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_core_start;
    logic        w_core_done;
    logic [31:0] w_mag1_in;
    logic [31:0] w_mag2_in;
    logic [63:0] w_core_res;
    logic [63:0] w_div_res;
    logic [63:0] w_mul_res;

    assign w_accept  = (r_state == ST_IDLE) & md.start & ~md.cancel;
    assign w_mag1_in = mag32(md.src1, ~md.op[0]);
    assign w_mag2_in = mag32(md.src2, ~md.op[0]);

`ifdef MUL_ITER_EN
    assign w_core_start = w_accept;
    assign w_mul_res    = sign_fix(r_op, r_src1, r_src2, w_core_res);
`else
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    assign w_core_start = w_accept & md.op[1];
    assign w_mag1       = mag32(r_src1, ~r_op[0]);
    assign w_mag2       = mag32(r_src2, ~r_op[0]);
    assign w_mul_res    = sign_fix(r_op, r_src1, r_src2, {32'd0, w_mag1} * {32'd0, w_mag2});
`endif

    // Divide by zero bypasses sign handling: quotient all ones, remainder is the raw dividend.
    assign w_div_res = (r_src2 == 32'd0) ? {r_src1, 32'hFFFF_FFFF}
                                         : sign_fix(r_op, r_src1, r_src2, w_core_res);

    div_core u_div_core (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_core_start),
        .i_cancel (md.cancel),
`ifdef MUL_ITER_EN
        .i_mul    (~md.op[1]),
`endif
        .i_opa    (w_mag1_in),
        .i_opb    (w_mag2_in),
        .o_done   (w_core_done),
        .o_res    (w_core_res)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_op    <= 2'd0;
            r_src1  <= 32'd0;
            r_src2  <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else if (md.cancel) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (md.start) begin
                        r_op    <= md.op;
                        r_src1  <= md.src1;
                        r_src2  <= md.src2;
                        r_state <= md.op[1] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL: begin
`ifdef MUL_ITER_EN
                    if (w_core_done) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end
`else
                    {r_hi, r_lo} <= w_mul_res;
                    r_done       <= 1'b1;
                    r_state      <= ST_DONE;
`endif
                end
                ST_DIV: begin
                    if (w_core_done) begin
                        {r_hi, r_lo} <= w_div_res;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md.stallreq = ~i_rst & (w_accept | (r_state == ST_MUL) | (r_state == ST_DIV));
    assign md.done     = r_done;
    assign md.hi_o     = r_hi;
    assign md.lo_o     = r_lo;
    assign md.hilo_bus = {r_done, r_done, r_hi, r_lo};

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the EX stage; produces the HI/LO write results consumed by the register file's HI/LO registers and forwarding path. Accepts MULT/MULTU/DIV/DIVU from EX, holds the pipeline with a stall request while computing, and emits a 66-bit HI/LO write bus in the register file's forwarding-bus format. Results are returned as a one-cycle write pulse.

## Interface
- No parameters; widths come from `defines.vh`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  EX holds a mul/div instruction; held high while stalled.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src1`  in  32  rs operand: multiplicand or dividend.
- `src2`  in  32  rt operand: multiplier or divisor.
- `cancel`  in  1  flush; aborts any operation.
- `stallreq`  out  1  pipeline stall request.
- `done`  out  1  one-cycle result pulse.
- `hi_o`  out  32  HI result: product[63:32] or remainder.
- `lo_o`  out  32  LO result: product[31:0] or quotient.
- `hilo_bus`  out  66  {done, done, hi_o, lo_o}: HI write enable, LO write enable, HI, LO.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + start + !cancel:
  - latch op, src1, src2.
  - go to MUL for op[1]=0, DIV for op[1]=1.
- Signed ops:
  - operate on magnitudes; two's-complement absolute value, so 0x80000000 gives 2^31 as unsigned.
  - product and quotient are negated when operand signs differ.
  - remainder takes the dividend's sign.
- DIV: restoring radix-2, one quotient bit per cycle, 32 iterations, then DONE.
- MUL: see Configuration; then DONE.
- DONE:
  - `done`=1; `hi_o`/`lo_o` are valid and registered.
  - next state IDLE unconditionally; `start` is ignored in DONE, so the instruction still in EX does not restart.
- `hi_o`/`lo_o` hold their last result until the next DONE.
- Divide by zero, all div ops: `lo_o`=0xFFFFFFFF, `hi_o`=latched src1; full DIV latency.
- DIV 0x80000000 / 0xFFFFFFFF: `lo_o`=0x80000000, `hi_o`=0.
- `cancel` in any state:
  - next state IDLE; no `done` pulse.
  - `hi_o`/`lo_o` unchanged.
  - cancel wins over a simultaneous start.
- `stallreq` = (IDLE & start & !cancel) | MUL | DIV. It is low in DONE and while `rst` is high.
- Reset values: state IDLE; `done`=0, `hi_o`=0, `lo_o`=0, `stallreq`=0; internal registers 0.
- `rst` mid-operation: same effect as cancel, and also clears `hi_o`/`lo_o`.

## Timing
- Cycle 0 is the cycle `start` is sampled in IDLE; `stallreq` is high combinationally in cycle 0.
- DIV: DIV state in cycles 1–32; DONE in cycle 33.
- MUL, macro undefined: MUL in cycle 1; DONE in cycle 2.
- MUL, macro defined: MUL in cycles 1–32; DONE in cycle 33.
- `stallreq` is high from cycle 0 through the last MUL/DIV cycle and drops in DONE, so EX advances on the DONE edge.
- Back-to-back: the next instruction's `start` is seen in IDLE the cycle after DONE.
- `hilo_bus` enables equal `done`; no extra latency to the register file's HI/LO write or forwarding.

## Configuration
- `MUL_ITER_EN` defined:
  - multiply is an iterative shift-add over 32 cycles, sharing the divider's 64-bit shift register and 33-bit adder.
  - no 32×32 multiplier is inferred.
- `MUL_ITER_EN` undefined:
  - MUL is a single cycle.
  - a combinational 32×32→64 product of the magnitudes is registered, with the sign fix applied.
- Division is identical in both builds.

## Structure
- `defines.vh` holds:
  - op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state encodings.
  - `HILO_BUS_WD`=66.
- Sub-module `div_core`:
  - restoring divider datapath: 64-bit remainder/quotient shift register, 33-bit subtractor, 5-bit iteration counter.
  - interface: `start`, `cancel`, `done`.
  - top-level `mul_div_unit` owns the FSM, sign handling, and the multiply path.

## Test plan
- DIVU src1=100, src2=7:
  - `stallreq` high cycles 0–32.
  - `done` in cycle 33 with `lo_o`=14, `hi_o`=2.
  - `hilo_bus`[65:64]=2'b11.
- DIV src1=0xFFFFFFF9, src2=2: `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- MULT 0xFFFFFFFF×2 gives `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFE. MULTU of the same operands gives `hi_o`=1, `lo_o`=0xFFFFFFFE. `done` in cycle 2 without the macro, cycle 33 with it.
- DIVU 5/0: `lo_o`=0xFFFFFFFF, `hi_o`=5 in cycle 33. DIV 0x80000000/0xFFFFFFFF: `lo_o`=0x80000000, `hi_o`=0.
- Cancel in cycle 10 of a DIV:
  - IDLE in cycle 11; no `done`; `hi_o`/`lo_o` keep their prior values.
  - a new `start` in cycle 11 is accepted.
- `start` held high through DONE, then a second DIVU issued in the next cycle: exactly one `done` per instruction, the second in cycle 33 of its own sequence. `rst` asserted mid-DIV returns all outputs to 0 next cycle.
